// File: rtl/mem_write_tracer_pkg.sv
// rtl/mem_write_tracer_pkg.sv - shared types and constants for the store-trace recorder
package tracer_pkg;

  // Capture FSM states; the encoding is visible on state_o
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  localparam int DROP_W = 16;

  // Entry layout at default widths; the top builds the same shape at its own widths
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] ts;
  } trace_entry_t;

endpackage

// File: rtl/mem_write_tracer_fifo.sv
// rtl/mem_write_tracer_fifo.sv - show-ahead trace FIFO with drop or overwrite on full
module tracer_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 80,
  parameter bit WRAP  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          wr_en;
  logic          cnt_inc;
  logic          cnt_dec;

  // A full FIFO still accepts a push when the head leaves this cycle or when overwriting
  assign pop_ok  = pop && (count != '0);
  assign full    = (count == FULL_CNT);
  assign wr_en   = push && (!full || pop_ok || WRAP);
  assign drop    = push && full && !pop_ok;
  assign cnt_inc = wr_en && !full && !pop_ok;
  assign cnt_dec = pop_ok && !push;
  assign valid   = (count != '0);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Entry storage; stale words are unreachable once the pointers are cleared
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; overwrite advances the read pointer past the lost entry
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok || (push && full && WRAP)) rd_ptr <= rd_ptr + 1'b1;
      if (cnt_inc)      count <= count + 1'b1;
      else if (cnt_dec) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_write_tracer.sv
// rtl/mem_write_tracer.sv - store-trace recorder top; TRACER_ASSERT_EN adds runtime checks
module mem_write_tracer
  import tracer_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int TSW       = 16,
  parameter int WRAP      = 0,
  parameter int CAP_LIMIT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm_i,
  input  logic                   stop_i,
  input  logic                   flush_i,
  input  logic [AW-1:0]          trig_addr_i,
  input  logic [AW-1:0]          win_lo_i,
  input  logic [AW-1:0]          win_hi_i,
  input  logic                   memwrite_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   rd_ready_i,
  output logic                   rd_valid_o,
  output logic [AW-1:0]          rd_addr_o,
  output logic [DW-1:0]          rd_data_o,
  output logic [TSW-1:0]         rd_ts_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic [1:0]             state_o
);

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TSW-1:0] ts;
  } entry_t;

  localparam logic [31:0] CAP_LIM = 32'(CAP_LIMIT);

  trace_state_t      state;
  logic [TSW-1:0]    ts;
  logic [31:0]       cap_cnt;
  logic [DROP_W-1:0] drop_cnt;
  entry_t            push_entry;
  entry_t            head;
  logic              push;
  logic              in_window;
  logic              trig_hit;
  logic              limit_hit;
  logic              dropped;

  // Trigger store ignores the window; afterwards only in-window stores qualify
  assign in_window = (addr_i >= win_lo_i) && (addr_i <= win_hi_i);
  assign trig_hit  = (addr_i == trig_addr_i);
  assign push      = memwrite_i && !flush_i &&
                     (((state == ARMED) && trig_hit) || ((state == CAPTURE) && in_window));
  assign limit_hit = (CAP_LIMIT != 0) && (cap_cnt + 32'd1 == CAP_LIM);

  assign push_entry.addr = addr_i;
  assign push_entry.data = data_i;
  assign push_entry.ts   = ts;

  tracer_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t)),
    .WRAP  (WRAP != 0)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .push  (push),
    .pop   (rd_ready_i),
    .din   (push_entry),
    .dout  (head),
    .valid (rd_valid_o),
    .count (count_o),
    .full  (full_o),
    .drop  (dropped)
  );

  assign rd_addr_o  = head.addr;
  assign rd_data_o  = head.data;
  assign rd_ts_o    = head.ts;
  assign drop_cnt_o = drop_cnt;
  assign state_o    = state;

  // Capture FSM: flush beats stop beats arm; a store alongside stop still counts
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      state   <= IDLE;
      cap_cnt <= '0;
    end else begin
      if (push) cap_cnt <= cap_cnt + 32'd1;
      if (stop_i && ((state == ARMED) || (state == CAPTURE))) begin
        state <= DONE;
      end else begin
        case (state)
          IDLE, DONE: if (arm_i) begin
            state   <= ARMED;
            cap_cnt <= '0;
          end
          ARMED:   if (push) state <= limit_hit ? DONE : CAPTURE;
          CAPTURE: if (push && limit_hit) state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Free-running timestamp; flush leaves it alone so traces stay comparable
  always_ff @(posedge clk) begin
    if (!reset) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  // Saturating count of entries lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!reset || flush_i)                      drop_cnt <= '0;
    else if (dropped && (drop_cnt != '1))       drop_cnt <= drop_cnt + 1'b1;
  end

`ifdef TRACER_ASSERT_EN
  a_count_max: assert property (@(posedge clk) disable iff (!reset)
    count_o <= ($clog2(DEPTH)+1)'(DEPTH));
  a_head_stable: assert property (@(posedge clk) disable iff (!reset)
    (rd_valid_o && !rd_ready_i && !flush_i && !(push && full_o))
      |=> $stable({rd_addr_o, rd_data_o, rd_ts_o}));
  a_no_idle_push: assert property (@(posedge clk) disable iff (!reset)
    push |-> ((state == ARMED) || (state == CAPTURE)));
  a_drop_mono: assert property (@(posedge clk) disable iff (!reset)
    !flush_i |=> (drop_cnt_o >= $past(drop_cnt_o)));
`endif

endmodule

// File: tb/tb_mem_write_tracer.sv
// tb/tb_mem_write_tracer.sv - randomized bench for mem_write_tracer against a queue model
module tb_mem_write_tracer;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, arm, stop, flush, memwrite, ready;
  logic [31:0] trig, lo, hi, addr, data;

  logic        valid_w [NI];
  logic [31:0] raddr_w [NI];
  logic [31:0] rdata_w [NI];
  logic [15:0] rts_w   [NI];
  logic [2:0]  cnt_w   [NI];
  logic        full_w  [NI];
  logic [15:0] drop_w  [NI];
  logic [1:0]  st_w    [NI];

  int n_cmp = 0;
  int n_err = 0;

  mem_write_tracer #(.AW(32), .DW(32), .DEPTH(DEPTH), .TSW(16), .WRAP(0), .CAP_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .arm_i(arm), .stop_i(stop), .flush_i(flush),
    .trig_addr_i(trig), .win_lo_i(lo), .win_hi_i(hi), .memwrite_i(memwrite),
    .addr_i(addr), .data_i(data), .rd_ready_i(ready), .rd_valid_o(valid_w[0]),
    .rd_addr_o(raddr_w[0]), .rd_data_o(rdata_w[0]), .rd_ts_o(rts_w[0]), .count_o(cnt_w[0]),
    .full_o(full_w[0]), .drop_cnt_o(drop_w[0]), .state_o(st_w[0]));

  mem_write_tracer #(.AW(32), .DW(32), .DEPTH(DEPTH), .TSW(16), .WRAP(1), .CAP_LIMIT(0)) dut1 (
    .clk(clk), .reset(reset), .arm_i(arm), .stop_i(stop), .flush_i(flush),
    .trig_addr_i(trig), .win_lo_i(lo), .win_hi_i(hi), .memwrite_i(memwrite),
    .addr_i(addr), .data_i(data), .rd_ready_i(ready), .rd_valid_o(valid_w[1]),
    .rd_addr_o(raddr_w[1]), .rd_data_o(rdata_w[1]), .rd_ts_o(rts_w[1]), .count_o(cnt_w[1]),
    .full_o(full_w[1]), .drop_cnt_o(drop_w[1]), .state_o(st_w[1]));

  mem_write_tracer #(.AW(32), .DW(32), .DEPTH(DEPTH), .TSW(16), .WRAP(0), .CAP_LIMIT(3)) dut2 (
    .clk(clk), .reset(reset), .arm_i(arm), .stop_i(stop), .flush_i(flush),
    .trig_addr_i(trig), .win_lo_i(lo), .win_hi_i(hi), .memwrite_i(memwrite),
    .addr_i(addr), .data_i(data), .rd_ready_i(ready), .rd_valid_o(valid_w[2]),
    .rd_addr_o(raddr_w[2]), .rd_data_o(rdata_w[2]), .rd_ts_o(rts_w[2]), .count_o(cnt_w[2]),
    .full_o(full_w[2]), .drop_cnt_o(drop_w[2]), .state_o(st_w[2]));

  typedef logic [79:0] ent_t;
  typedef ent_t q_t[$];
  q_t          mq    [NI];
  int          m_st  [NI];
  int          m_cap [NI];
  int          m_drop[NI];
  int unsigned m_ts;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: one edge of every instance, written as queue operations on the rules
  task automatic model_step();
    ent_t e;
    bit   pop, cap, wrap;
    int   lim;
    for (int k = 0; k < NI; k++) begin
      wrap = (k == 1);
      lim  = (k == 2) ? 3 : 0;
      if (!reset || flush) begin
        mq[k].delete();
        m_drop[k] = 0;
        m_st[k]   = 0;
        m_cap[k]  = 0;
        continue;
      end
      pop = ready && (mq[k].size() > 0);
      cap = memwrite && (((m_st[k] == 1) && (addr == trig)) ||
                         ((m_st[k] == 2) && (addr >= lo) && (addr <= hi)));
      if (pop) void'(mq[k].pop_front());
      if (cap) begin
        e = {addr, data, m_ts[15:0]};
        if (mq[k].size() < DEPTH) begin
          mq[k].push_back(e);
        end else begin
          if (wrap) begin
            void'(mq[k].pop_front());
            mq[k].push_back(e);
          end
          if (m_drop[k] < 65535) m_drop[k]++;
        end
        m_cap[k]++;
      end
      if (stop && (m_st[k] == 1 || m_st[k] == 2)) begin
        m_st[k] = 3;
      end else if ((m_st[k] == 0 || m_st[k] == 3) && arm) begin
        m_st[k]  = 1;
        m_cap[k] = 0;
      end else if (cap) begin
        if (m_st[k] == 1) m_st[k] = 2;
        if (lim != 0 && m_cap[k] == lim) m_st[k] = 3;
      end
    end
    if (!reset) m_ts = 0;
    else        m_ts = (m_ts + 1) & 32'hFFFF;
  endtask

  task automatic check_all();
    ent_t e;
    int   sz;
    for (int k = 0; k < NI; k++) begin
      sz = mq[k].size();
      e  = (sz > 0) ? mq[k][0] : '0;
      check($sformatf("d%0d_valid", k), 64'(valid_w[k]), 64'(sz > 0));
      check($sformatf("d%0d_count", k), 64'(cnt_w[k]),   64'(sz));
      check($sformatf("d%0d_full", k),  64'(full_w[k]),  64'(sz == DEPTH));
      check($sformatf("d%0d_drop", k),  64'(drop_w[k]),  64'(m_drop[k]));
      check($sformatf("d%0d_state", k), 64'(st_w[k]),    64'(m_st[k]));
      check($sformatf("d%0d_addr", k),  64'(raddr_w[k]), 64'(e[79:48]));
      check($sformatf("d%0d_data", k),  64'(rdata_w[k]), 64'(e[47:16]));
      check($sformatf("d%0d_ts", k),    64'(rts_w[k]),   64'(e[15:0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic store(input logic [31:0] a);
    memwrite = 1'b1;
    addr     = a;
    data     = $urandom;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; stop = 1'b0; flush = 1'b0; memwrite = 1'b0; ready = 1'b0;
    trig = 32'h40; lo = 32'h40; hi = 32'h7F; addr = '0; data = '0;
    m_ts = 0;
    for (int k = 0; k < NI; k++) begin
      m_st[k] = 0; m_cap[k] = 0; m_drop[k] = 0;
    end
    tick();
    tick();
    check("rst_state", 64'(st_w[0]), 64'd0);
    check("rst_valid", 64'(valid_w[0]), 64'd0);
    reset = 1'b1;

    arm = 1'b1; tick(); arm = 1'b0;
    store(32'h10);
    store(32'h40);
    store(32'h44);
    check("tp_state",  64'(st_w[0]), 64'd2);
    check("tp_count",  64'(cnt_w[0]), 64'd2);
    check("tp_head",   64'(raddr_w[0]), 64'h40);

    store(32'h48); store(32'h4C); store(32'h50); store(32'h54);
    check("nowrap_count", 64'(cnt_w[0]), 64'd4);
    check("nowrap_full",  64'(full_w[0]), 64'd1);
    check("nowrap_drop",  64'(drop_w[0]), 64'd2);
    check("nowrap_head",  64'(raddr_w[0]), 64'h40);
    check("wrap_count",   64'(cnt_w[1]), 64'd4);
    check("wrap_drop",    64'(drop_w[1]), 64'd2);
    check("wrap_head",    64'(raddr_w[1]), 64'h48);
    check("lim_count",    64'(cnt_w[2]), 64'd3);
    check("lim_state",    64'(st_w[2]), 64'd3);

    ready = 1'b1; store(32'h58); ready = 1'b0;
    check("fullrw_count", 64'(cnt_w[0]), 64'd4);
    check("fullrw_drop",  64'(drop_w[0]), 64'd2);
    check("fullrw_head",  64'(raddr_w[0]), 64'h44);

    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0; store(32'h60); reset = 1'b1;
    check("midrst_valid", 64'(valid_w[0]), 64'd0);
    check("midrst_state", 64'(st_w[0]), 64'd0);
    check("midrst_drop",  64'(drop_w[1]), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      arm      = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 40) == 0);
      flush    = ($urandom_range(0, 80) == 0);
      reset    = ($urandom_range(0, 400) != 0);
      memwrite = ($urandom_range(0, 1) == 1);
      ready    = ($urandom_range(0, 2) == 0);
      addr     = 32'h30 + 32'(4 * $urandom_range(0, 24));
      data     = $urandom;
      if ($urandom_range(0, 50) == 0) begin
        lo   = 32'h40 + 32'(4 * $urandom_range(0, 4));
        hi   = lo + 32'(4 * $urandom_range(0, 8));
        trig = 32'h30 + 32'(4 * $urandom_range(0, 24));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Synthesizable, parametrised store-trace recorder that sits beside the pipelined MIPS core.
- Taps the memory-stage write strobe, address and data (memwriteM, aluoutM, writedataM).
- Records qualifying stores with a cycle timestamp into an on-chip FIFO, armed and triggered by a small FSM.
- Drained through a valid/ready port, so store traffic can be checked on silicon and in simulation without $display monitors.

Parameters:
- AW, 32, store address width.
- DW, 32, store data width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- TSW, 16, timestamp counter width.
- WRAP, 0, full-FIFO policy: 0 drops the new entry, 1 overwrites the oldest.
- CAP_LIMIT, 0, number of captures before the FSM enters DONE; 0 means unlimited.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- arm_i  in  1  pulse: IDLE/DONE -> ARMED.
- stop_i  in  1  pulse: ARMED/CAPTURE -> DONE.
- flush_i  in  1  pulse: empty the FIFO, clear drop count, FSM -> IDLE.
- trig_addr_i  in  AW  address of the store that starts capture.
- win_lo_i  in  AW  lower bound of the capture window, inclusive.
- win_hi_i  in  AW  upper bound of the capture window, inclusive.
- memwrite_i  in  1  store strobe from the memory stage.
- addr_i  in  AW  store address.
- data_i  in  DW  store data.
- rd_ready_i  in  1  consumer accepts the head entry.
- rd_valid_o  out  1  FIFO not empty.
- rd_addr_o  out  AW  head entry address.
- rd_data_o  out  DW  head entry data.
- rd_ts_o  out  TSW  head entry timestamp.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  count_o == DEPTH.
- drop_cnt_o  out  16  lost or overwritten entries, saturating.
- state_o  out  2  FSM state (trace_state_t).

Behaviour:
- Reset (reset==0 at a clk edge): FSM=IDLE, pointers=0, count_o=0, rd_valid_o=0, full_o=0, drop_cnt_o=0, timestamp=0, capture counter=0, rd_* outputs=0.
- Timestamp: increments every cycle while out of reset, wraps modulo 2^TSW.
- FSM encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE: arm_i -> ARMED.
  - ARMED: a store with addr_i==trig_addr_i is captured (window ignored for the trigger store) -> CAPTURE.
  - CAPTURE: any store with win_lo_i <= addr_i <= win_hi_i (unsigned) is captured. When the capture count reaches CAP_LIMIT (nonzero) -> DONE, on the same edge as the last capture.
  - stop_i in ARMED or CAPTURE -> DONE. DONE: arm_i -> ARMED and the capture counter clears; FIFO contents are kept.
  - Priority when asserted together: flush_i > stop_i > arm_i. A store in the same cycle as stop_i is still captured if qualifying.
- Capture latency: a store captured at edge N gives rd_valid_o=1 and the entry at rd_* after edge N. Read is show-ahead: the head is presented combinationally from storage.
- Pop: rd_valid_o && rd_ready_i at an edge. Pop when empty has no effect.
- Full FIFO with push and no pop:
  - WRAP=0: entry discarded, drop_cnt_o+1.
  - WRAP=1: oldest entry replaced, read pointer advances, drop_cnt_o+1, count unchanged.
- Full FIFO with push and pop together: both happen, no drop. Empty FIFO with push and pop together: push only.
- drop_cnt_o saturates at 16'hFFFF.
- Pointers wrap modulo DEPTH.
- flush_i clears pointers, count and drop count. It does not reset the timestamp.
- Reset asserted mid-capture: everything returns to reset values; no partial entry survives.

Optional Feature:
- TRACER_ASSERT_EN defined: concurrent assertions (not synthesized) check:
  - count_o never exceeds DEPTH;
  - rd_* stay stable while rd_valid_o && !rd_ready_i;
  - no push in IDLE or DONE;
  - drop_cnt_o never decreases except on flush or reset.
- Undefined: no assertion code; RTL behaviour is identical either way.

Decomposition:
- Package tracer_pkg: trace_state_t enum (IDLE, ARMED, CAPTURE, DONE), DROP_W=16 constant, and a trace_entry_t packed-struct template pattern (addr, data, ts).
- One sub-module: tracer_fifo (parametrised DEPTH/width storage with push, pop, overwrite and occupancy). The FSM, qualification logic and timestamp stay in the top module.

Test Plan:
- Reset, then arm_i, then stores to 0x10, 0x40 (trig 0x40), 0x44, window 0x40–0x7F -> entries 0x40, 0x44 in order; 0x10 not captured; state_o=2.
- DEPTH=4, WRAP=0, six window stores, no reads -> count_o=4, full_o=1, drop_cnt_o=2, first four entries retained.
- Same stimulus with WRAP=1 -> count_o=4, drop_cnt_o=2, head entry is the 3rd store.
- CAP_LIMIT=3, five qualifying stores -> three entries; state_o=3 after the 3rd capture; later stores ignored.
- Full FIFO with a simultaneous store and rd_ready_i=1 -> count_o stays 4, drop_cnt_o unchanged, new entry at the tail.
- Hold rd_ready_i=0 with data present, then pulse reset low mid-capture -> rd_* stable while held; after reset, rd_valid_o=0, state_o=0, drop_cnt_o=0.
